// File: rtl/serializer_pkg.sv
// Word-size constants shared with the fir_filter serial receive path,
// plus the FSM state type used by the serializer.
package serializer_pkg;

  localparam int FIR_WORD_LEN = 24;

  // Counter width for an index 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/serializer_if.sv
// Parallel-word valid/ready handshake feeding the serializer.
interface serializer_if #(
  parameter int LENGTH = serializer_pkg::FIR_WORD_LEN
);

  logic [LENGTH-1:0] iv_din;
  logic              i_din_valid;
  logic              o_din_ready;

  modport master (output iv_din, output i_din_valid, input  o_din_ready);
  modport slave  (input  iv_din, input  i_din_valid, output o_din_ready);

endinterface

// File: rtl/serializer.sv
// Parallel-to-serial converter, LSB first, with a one-word holding buffer so
// consecutive words leave back-to-back; o_dout_valid marks each word's last bit.
module serializer
  import serializer_pkg::*;
#(
  parameter int LENGTH = FIR_WORD_LEN
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  serializer_if.slave  s_if,
  output logic         o_dout,
  output logic         o_dout_valid,
  output logic         o_active,
  output logic         o_busy
);

  localparam int              CNT_W = cnt_width(LENGTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LENGTH - 1);

  ser_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [LENGTH-1:0] r_shift;
  logic [LENGTH-1:0] r_hold;
  logic              r_hold_full;
  logic              r_dout;
  logic              r_dout_valid;
  logic              r_active;

  ser_state_e        w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_load;
  logic              w_accept;
  logic              w_out_upd;
  logic              w_dout_nxt;
  logic              w_dvld_nxt;
  logic              w_active_nxt;

  // Ready depends only on the buffer flag, so an accept can never coincide
  // with a reload and the held word is never overwritten.
  assign s_if.o_din_ready = ~r_hold_full;
  assign w_accept         = s_if.i_din_valid & ~r_hold_full;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_load       = 1'b0;
    w_out_upd    = 1'b0;
    w_dout_nxt   = 1'b0;
    w_dvld_nxt   = 1'b0;
    w_active_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_out_upd = i_en;
        if (r_hold_full) begin
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (i_en) begin
          w_out_upd    = 1'b1;
          w_dout_nxt   = r_shift[r_cnt];
          w_active_nxt = 1'b1;
          w_dvld_nxt   = (r_cnt == LAST);
          if (r_cnt == LAST) begin
            if (r_hold_full) begin
              w_load    = 1'b1;
              w_cnt_nxt = '0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_active     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_shift     <= r_hold;
        r_hold_full <= 1'b0;
      end else if (w_accept) begin
        r_hold      <= s_if.iv_din;
        r_hold_full <= 1'b1;
      end
      if (w_out_upd) begin
        r_dout       <= w_dout_nxt;
        r_dout_valid <= w_dvld_nxt;
        r_active     <= w_active_nxt;
      end
    end
  end

  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_active     = r_active;
  assign o_busy       = (r_state == ST_SHIFT) | r_hold_full;

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: table vectors, hand-written corner sequences and a
// random run, all checked against a queue scoreboard and a bit-collecting deserializer.
module tb_serializer;
  import serializer_pkg::*;

  localparam int L = 24;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic dout, dvld, active, busy;

  serializer_if #(.LENGTH(L)) bus ();

  serializer #(.LENGTH(L)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .s_if        (bus),
    .o_dout      (dout),
    .o_dout_valid(dvld),
    .o_active    (active),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Deserializer / scoreboard state
  logic         en_q, rst_q, hs_q;
  logic [L-1:0] din_q;
  int           en_period;
  int           en_ph;
  int           en_idx, act_cnt, vld_cnt, acc_cnt, first_act, last_act;
  int           vld_pos[$];
  logic         bits[$];
  logic [L-1:0] exp_q[$];
  logic [L-1:0] got_q[$];
  logic [7:0]   first8;
  logic         p_dout, p_act, p_vld;

  typedef struct {
    logic [L-1:0] din;
    int           period;
    logic [L-1:0] exp_word;
    logic [7:0]   exp_first8;
    int           exp_act;
    int           exp_vld;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [L-1:0] w;
    if (hs_q) begin
      exp_q.push_back(din_q);
      acc_cnt++;
    end
    if (!rst_q) begin
      if (en_q) begin
        en_idx++;
        if (active) begin
          bits.push_back(dout);
          if (act_cnt < 8) first8[act_cnt] = dout;
          act_cnt++;
          if (first_act < 0) first_act = en_idx;
          last_act = en_idx;
        end
        if (dvld) begin
          vld_cnt++;
          vld_pos.push_back(act_cnt);
          check("vld_align", 32'(act_cnt % L), 32'd0);
          if (bits.size() >= L) begin
            for (int i = 0; i < L; i++) w[i] = bits[bits.size() - L + i];
            got_q.push_back(w);
            if (exp_q.size() == 0) check("sb_unexpected_word", 32'(w), 32'hFFFF_FFFF);
            else check("sb_word", 32'(w), 32'(exp_q.pop_front()));
          end else begin
            check("vld_bit_count", 32'(bits.size()), 32'(L));
          end
          bits.delete();
        end
      end else begin
        check("hold_when_en0", {29'd0, dout, active, dvld}, {29'd0, p_dout, p_act, p_vld});
      end
    end
    p_dout = dout;
    p_act  = active;
    p_vld  = dvld;
  endtask

  // Advance one clock: capture pre-edge inputs, pass the edge, observe, pick next i_en
  task automatic step();
    en_q  = en;
    rst_q = rst;
    hs_q  = bus.i_din_valid && bus.o_din_ready && !rst;
    din_q = bus.iv_din;
    @(negedge clk);
    monitor();
    if (en_period == 0) en = ($urandom_range(0, 2) != 0);
    else                en = ((en_ph % en_period) == 0);
    en_ph++;
  endtask

  task automatic clear_stats();
    act_cnt = 0; vld_cnt = 0; acc_cnt = 0; en_idx = 0;
    first_act = -1; last_act = -1; first8 = '0;
    vld_pos.delete(); got_q.delete(); bits.delete();
  endtask

  task automatic set_period(input int p);
    en_period = p;
    en_ph = 0;
    step();
  endtask

  task automatic offer(input logic [L-1:0] w, input bit drop);
    int t;
    t = 0;
    bus.iv_din      = w;
    bus.i_din_valid = 1'b1;
    while (!bus.o_din_ready && t < 500) begin
      step();
      t++;
    end
    if (t >= 500) check("accept_timeout", 32'(t), 32'd0);
    step();
    if (drop) bus.i_din_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (busy && t < 5000) begin
      step();
      t++;
    end
    if (t >= 5000) check("drain_timeout", 32'(t), 32'd0);
    repeat (12) step();
  endtask

  initial begin
    logic [L-1:0] w3[3];
    int t;

    vecs[0] = '{24'hA5C3F0, 1, 24'hA5C3F0, 8'hF0, 24, 1};
    vecs[1] = '{24'h00000F, 3, 24'h00000F, 8'h0F, 24, 1};
    vecs[2] = '{24'h800001, 2, 24'h800001, 8'h01, 24, 1};
    vecs[3] = '{24'h5A5A5A, 1, 24'h5A5A5A, 8'h5A, 24, 1};

    rst = 1'b1; en = 1'b1; en_period = 1; en_ph = 0;
    bus.iv_din = '0; bus.i_din_valid = 1'b0;
    p_dout = 1'b0; p_act = 1'b0; p_vld = 1'b0;
    clear_stats();

    // Reset state
    repeat (3) step();
    check("rst_dout",   32'(dout),            32'd0);
    check("rst_active", 32'(active),          32'd0);
    check("rst_dvld",   32'(dvld),            32'd0);
    check("rst_busy",   32'(busy),            32'd0);
    check("rst_ready",  32'(bus.o_din_ready), 32'd1);
    rst = 1'b0;
    step();

    // Table-driven single words at various bit rates
    for (int v = 0; v < 4; v++) begin
      set_period(vecs[v].period);
      clear_stats();
      offer(vecs[v].din, 1'b1);
      drain();
      check("vec_active_bits", 32'(act_cnt),     32'(vecs[v].exp_act));
      check("vec_vld_pulses",  32'(vld_cnt),     32'(vecs[v].exp_vld));
      check("vec_first8",      32'(first8),      32'(vecs[v].exp_first8));
      check("vec_words",       32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) check("vec_word", 32'(got_q[0]), 32'(vecs[v].exp_word));
    end

    // First bit appears on the second enabled edge after accept
    set_period(1);
    clear_stats();
    offer(24'h000001, 1'b1);
    check("lat_e0_active", 32'(active), 32'd0);
    step();
    check("lat_e1_active", 32'(active), 32'd0);
    step();
    check("lat_e2_active", 32'(active), 32'd1);
    check("lat_e2_dout",   32'(dout),   32'd1);
    drain();

    // Back-to-back words with valid held
    clear_stats();
    offer(24'h000001, 1'b0);
    offer(24'h800000, 1'b1);
    check("b2b_ready_full", 32'(bus.o_din_ready), 32'd0);
    check("b2b_busy",       32'(busy),            32'd1);
    drain();
    check("b2b_active_bits", 32'(act_cnt),                32'd48);
    check("b2b_contiguous",  32'(last_act - first_act + 1), 32'd48);
    check("b2b_vld_pulses",  32'(vld_cnt),                32'd2);
    if (vld_pos.size() >= 2) begin
      check("b2b_vld_pos0", 32'(vld_pos[0]), 32'd24);
      check("b2b_vld_pos1", 32'(vld_pos[1]), 32'd48);
    end

    // Reset in the middle of a word with a second word held
    clear_stats();
    offer(24'hFFFFFF, 1'b0);
    offer(24'hFFFFFF, 1'b1);
    t = 0;
    while (act_cnt < 10 && t < 500) begin
      step();
      t++;
    end
    check("mid_hold_full", 32'(bus.o_din_ready), 32'd0);
    rst = 1'b1;
    step();
    check("mid_rst_dout",   32'(dout),   32'd0);
    check("mid_rst_active", 32'(active), 32'd0);
    check("mid_rst_dvld",   32'(dvld),   32'd0);
    check("mid_rst_busy",   32'(busy),   32'd0);
    rst = 1'b0;
    exp_q.delete();
    clear_stats();
    step();
    check("mid_ready_after", 32'(bus.o_din_ready), 32'd1);
    repeat (60) step();
    check("mid_no_vld",    32'(vld_cnt), 32'd0);
    check("mid_no_active", 32'(act_cnt), 32'd0);

    // Three words with valid held throughout
    set_period(2);
    clear_stats();
    w3[0] = 24'h123456; w3[1] = 24'hFEDCBA; w3[2] = 24'h0F0F0F;
    offer(w3[0], 1'b0);
    offer(w3[1], 1'b0);
    offer(w3[2], 1'b1);
    drain();
    check("three_accepts", 32'(acc_cnt),      32'd3);
    check("three_words",   32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (got_q.size() > i) check("three_word", 32'(got_q[i]), 32'(w3[i]));

    // Random words, random bit-rate enable, random gaps
    set_period(0);
    clear_stats();
    for (int n = 0; n < 25; n++) begin
      offer(L'($urandom), 1'b1);
      repeat ($urandom_range(0, 5)) step();
    end
    drain();
    check("rnd_words",    32'(got_q.size()), 32'd25);
    check("rnd_accepts",  32'(acc_cnt),      32'd25);
    check("rnd_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
